// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode and FSM definitions for the pipeline hazard controller.
package hazard_stall_ctrl_pkg;

   // RISC-V opcode[6:2] for conditional branches
   localparam logic [4:0] OpcodeBranch = 5'b11000;

   typedef enum logic [0:0] {
      StIdle,
      StStall
   } hz_state_e;

endpackage

// File: rtl/hazard_dep_detect.sv
// Combinational dependency check: returns the stall length N demanded by the ID-stage instruction.
module hazard_dep_detect
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 3
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [4:0]        id_opcode,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_mem_read,
   output logic [CNT_W-1:0]  n
);

   logic        is_branch;
   logic        ex_hit;
   logic        mem_hit;
   int unsigned need;

   assign is_branch = (id_opcode == OpcodeBranch);
   // x0 is never a real producer
   assign ex_hit  = (ex_rd != '0) && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
   assign mem_hit = (mem_rd != '0) && ((id_rs1 == mem_rd) || (id_rs2 == mem_rd));

   always_comb begin
      need = 0;
      if (ex_hit && ex_mem_read) need = LOAD_LAT;
      if (is_branch) begin
         if (ex_hit && ex_reg_write && !ex_mem_read && need < 1) need = 1;
         if (ex_hit && ex_mem_read) need = LOAD_LAT + 1;
         if (mem_hit && mem_mem_read && need < LOAD_LAT) need = LOAD_LAT;
      end
      n = CNT_W'(need);
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: stall sequencing, memory freeze and mispredict flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [4:0]        id_opcode,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_mem_read,
   input  logic              mem_busy,
   input  logic              br_mispredict,
   output logic              pc_hold,
   output logic              if_id_hold,
   output logic              id_ex_bubble,
   output logic              if_id_flush,
   output logic              stall_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_flush_cnt
`endif
);

   logic [CNT_W-1:0] n;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   hz_state_e        state_q, state_d;
   logic             sync_q, run_q;
   logic             stall;

   hazard_dep_detect #(
      .REG_AW  (REG_AW),
      .LOAD_LAT(LOAD_LAT),
      .CNT_W   (CNT_W)
   ) u_dep_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_opcode   (id_opcode),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .ex_reg_write(ex_reg_write),
      .mem_rd      (mem_rd),
      .mem_mem_read(mem_mem_read),
      .n           (n)
   );

   // Reset asserts asynchronously; run_q releases two clocks after rst rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 1'b0;
         run_q  <= 1'b0;
      end else begin
         sync_q <= 1'b1;
         run_q  <= sync_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall        = 1'b0;
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (!run_q) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (mem_busy) begin
         // Freeze: state and count hold, no bubble, mispredict ignored
         pc_hold    = 1'b1;
         if_id_hold = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (n != '0) begin
                  stall = 1'b1;
                  if (n > CNT_W'(1)) begin
                     cnt_d   = n - CNT_W'(1);
                     state_d = StStall;
                  end
               end
            end
            StStall: begin
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  stall = 1'b1;
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_d = StIdle;
               end
            end
         endcase
         pc_hold      = stall;
         if_id_hold   = stall;
         id_ex_bubble = stall;
         if_id_flush  = br_mispredict & ~stall;
      end
   end

   assign stall_busy = run_q && (state_q == StStall);

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if ((id_ex_bubble || (mem_busy && run_q)) && perf_stall_cyc != '1) begin
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         end
         if (if_id_flush && perf_flush_cnt != '1) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
